mem_wb_stage: RTL and testbench
===============================

Name: mem_wb_stage

Overview:
- Memory-access stage of the 5-stage RISC-V pipeline, sitting directly downstream of the EX/MEM register.
- Consumes the EX/MEM outputs and resolves branches (pcsrc).
- Performs word loads/stores through a variable-latency req/ack data-memory port, with a timeout counter and stall generation.
- Ends in the MEM/WB pipeline register that feeds write-back.

Parameters:
- TIMEOUT, 16, maximum BUSY cycles to wait for mem_ack before aborting the access.
- CNT_W, 5, width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clock  in  1  pipeline clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state and outputs.
- wb_ctl  in  2  write-back controls from EX/MEM ([1]=regwrite, [0]=memtoreg).
- branch  in  1  branch control from EX/MEM.
- memread  in  1  load control from EX/MEM.
- memwrite  in  1  store control from EX/MEM.
- add_result  in  32  branch target from EX/MEM.
- zero  in  1  ALU zero flag from EX/MEM.
- alu_result  in  32  ALU result / memory address from EX/MEM.
- rdata2  in  32  store data from EX/MEM.
- rd  in  5  destination register from EX/MEM.
- pcsrc  out  1  take branch; combinational.
- branch_target  out  32  equals add_result; combinational.
- stall  out  1  combinational; upstream stages must hold their contents while high.
- mem_req  out  1  data-memory request; registered.
- mem_we  out  1  1=store, 0=load; registered.
- mem_addr  out  32  word address; registered.
- mem_wdata  out  32  store data; registered.
- mem_rdata  in  32  load data; valid in the cycle mem_ack=1.
- mem_ack  in  1  access-complete strobe, one cycle.
- wb_ctlout  out  2  MEM/WB write-back controls.
- read_data  out  32  MEM/WB load data.
- alu_result_out  out  32  MEM/WB ALU result.
- rd_out  out  5  MEM/WB destination register.
- mem_err  out  1  registered one-cycle pulse marking a faulted operation.

Behaviour:
- Reset (asynchronous, active-high): state=IDLE, counter=0. All registered outputs go to 0: mem_req, mem_we, mem_addr, mem_wdata, wb_ctlout, read_data, alu_result_out, rd_out, mem_err. Reset mid-access abandons the request; no completion is reported.
- memop = memread | memwrite.
- Fault conditions:
  - misaligned = memop & (alu_result[1:0] != 0).
  - illegal = memread & memwrite.
  - A faulted op issues no memory request.
- FSM states:
  - IDLE:
    - No memop or a faulted op: stall=0; MEM/WB loads the inputs this edge.
    - Faulted op: MEM/WB loads with wb_ctlout forced to 0, and mem_err=1 for one cycle.
    - Valid memop: stall=1. The next edge registers mem_req=1, mem_we=memwrite, mem_addr=alu_result, mem_wdata=rdata2, clears the counter, and moves to BUSY. MEM/WB loads a bubble (all fields 0).
  - BUSY:
    - stall=1; MEM/WB loads a bubble each cycle; the counter increments.
    - mem_ack=1: capture mem_rdata (0 for stores), mem_req goes to 0, move to DONE.
    - Counter reaches TIMEOUT-1 without mem_ack: mem_req goes to 0, captured data=0, err flag set, move to DONE.
  - DONE:
    - stall=0; MEM/WB loads the held inputs with read_data=captured data.
    - On timeout: wb_ctlout=0 and mem_err=1.
    - Move to IDLE at the same edge.
- Completion latency: minimum 3 cycles from op presented to MEM/WB load (IDLE, BUSY with ack in its first cycle, DONE), so stall is high for 2 cycles.
- Branch resolution: pcsrc = branch & zero & ~stall.
- mem_ack outside BUSY is ignored, including a stale ack arriving after reset.
- mem_req stays stable from assertion until the ack or timeout edge.
- MEM/WB fields for non-load ops: read_data=0.

Test Plan:
- ALU op, no memop: wb_ctl=2'b10, alu_result=0x1234, rd=5 -> next edge wb_ctlout=2'b10, alu_result_out=0x1234, rd_out=5, stall never asserted.
- Load, addr 0x40, ack on the 3rd BUSY cycle with mem_rdata=0xDEADBEEF -> mem_req=1, mem_we=0, mem_addr=0x40 for 3 cycles; stall high 4 cycles; bubbles in MEM/WB during the stall; then read_data=0xDEADBEEF, wb_ctlout=2'b11.
- Store, addr 0x80, rdata2=0xCAFE0001, immediate ack -> mem_we=1, mem_wdata=0xCAFE0001; stall high 2 cycles; wb_ctlout=0 passthrough; mem_err=0.
- Misaligned load at addr 0x41, and separately memread=memwrite=1 -> no mem_req; mem_err pulses 1 cycle; wb_ctlout=0; stall=0.
- No ack for TIMEOUT=16 cycles -> mem_req drops after 16 BUSY cycles; mem_err=1; read_data=0; wb_ctlout=0. Then assert reset mid-BUSY on a second access -> all outputs 0, state IDLE; a later stray ack is ignored.
- branch=1, zero=1, add_result=0x100 -> pcsrc=1, branch_target=0x100 the same cycle. Same with zero=0 -> pcsrc=0.

Source files
------------

// File: rtl/mem_wb_stage.sv
// mem_wb_stage: memory-access stage of the 5-stage RISC-V pipeline.
//
// It takes the EX/MEM register contents, resolves the branch decision, and
// runs word loads/stores through a req/ack data-memory port whose latency
// varies. The stage stalls upstream while an access is in flight. An access
// that gets no ack is abandoned after TIMEOUT busy cycles. The stage ends in
// the MEM/WB pipeline register.
//
// Ports:
//   clock, reset                 rising-edge clock, async active-high reset
//   wb_ctl[1:0]                  {regwrite, memtoreg} from EX/MEM
//   branch, zero, add_result     branch resolution inputs
//   memread, memwrite            memory operation controls
//   alu_result, rdata2, rd       address / ALU result, store data, dest reg
//   pcsrc, branch_target         branch outputs (combinational)
//   stall                        hold upstream stages (combinational)
//   mem_req, mem_we, mem_addr,
//   mem_wdata                    registered data-memory request
//   mem_rdata, mem_ack           data-memory response
//   wb_ctlout, read_data,
//   alu_result_out, rd_out       MEM/WB register
//   mem_err                      one-cycle pulse for a faulted operation
module mem_wb_stage #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [1:0]  wb_ctl,
  input  logic        branch,
  input  logic        memread,
  input  logic        memwrite,
  input  logic [31:0] add_result,
  input  logic        zero,
  input  logic [31:0] alu_result,
  input  logic [31:0] rdata2,
  input  logic [4:0]  rd,
  output logic        pcsrc,
  output logic [31:0] branch_target,
  output logic        stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic [1:0]  wb_ctlout,
  output logic [31:0] read_data,
  output logic [31:0] alu_result_out,
  output logic [4:0]  rd_out,
  output logic        mem_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_r, state_s;
  logic [CNT_W-1:0]   cnt_r, cnt_s;
  logic               mem_req_r, mem_req_s;
  logic               mem_we_r, mem_we_s;
  logic [31:0]        mem_addr_r, mem_addr_s;
  logic [31:0]        mem_wdata_r, mem_wdata_s;
  logic [31:0]        cap_data_r, cap_data_s;
  logic               tout_r, tout_s;
  logic [1:0]         hold_wb_r, hold_wb_s;
  logic [31:0]        hold_alu_r, hold_alu_s;
  logic [4:0]         hold_rd_r, hold_rd_s;
  logic [1:0]         wb_ctlout_r, wb_ctlout_s;
  logic [31:0]        read_data_r, read_data_s;
  logic [31:0]        alu_out_r, alu_out_s;
  logic [4:0]         rd_out_r, rd_out_s;
  logic               mem_err_r, mem_err_s;
  logic               stall_s;

  logic memop_s;
  logic misaligned_s;
  logic illegal_s;
  logic fault_s;

  assign memop_s      = memread | memwrite;
  assign misaligned_s = memop_s & (alu_result[1:0] != 2'b00);
  assign illegal_s    = memread & memwrite;
  assign fault_s      = misaligned_s | illegal_s;

  // A branch sitting behind a stalled memory op must not redirect the PC yet.
  assign pcsrc         = branch & zero & ~stall_s;
  assign branch_target = add_result;
  assign stall         = stall_s;

  assign mem_req        = mem_req_r;
  assign mem_we         = mem_we_r;
  assign mem_addr       = mem_addr_r;
  assign mem_wdata      = mem_wdata_r;
  assign wb_ctlout      = wb_ctlout_r;
  assign read_data      = read_data_r;
  assign alu_result_out = alu_out_r;
  assign rd_out         = rd_out_r;
  assign mem_err        = mem_err_r;

  // Next-state, memory-port and MEM/WB next values; MEM/WB defaults to a bubble
  always_comb begin
    state_s     = state_r;
    cnt_s       = cnt_r;
    mem_req_s   = mem_req_r;
    mem_we_s    = mem_we_r;
    mem_addr_s  = mem_addr_r;
    mem_wdata_s = mem_wdata_r;
    cap_data_s  = cap_data_r;
    tout_s      = tout_r;
    hold_wb_s   = hold_wb_r;
    hold_alu_s  = hold_alu_r;
    hold_rd_s   = hold_rd_r;
    wb_ctlout_s = 2'b00;
    read_data_s = 32'h0000_0000;
    alu_out_s   = 32'h0000_0000;
    rd_out_s    = 5'd0;
    mem_err_s   = 1'b0;
    stall_s     = 1'b0;

    case (state_r)
      IDLE: begin
        if (memop_s && !fault_s) begin
          stall_s     = 1'b1;
          state_s     = BUSY;
          cnt_s       = {CNT_W{1'b0}};
          mem_req_s   = 1'b1;
          mem_we_s    = memwrite;
          mem_addr_s  = alu_result;
          mem_wdata_s = rdata2;
          cap_data_s  = 32'h0000_0000;
          tout_s      = 1'b0;
          // Keep a private copy so completion does not depend on upstream timing.
          hold_wb_s   = wb_ctl;
          hold_alu_s  = alu_result;
          hold_rd_s   = rd;
        end else begin
          // Plain ALU op passes straight through; a faulted op is retired
          // without write-back and flagged.
          wb_ctlout_s = fault_s ? 2'b00 : wb_ctl;
          alu_out_s   = alu_result;
          rd_out_s    = rd;
          mem_err_s   = fault_s;
        end
      end
      BUSY: begin
        stall_s = 1'b1;
        cnt_s   = cnt_r + CNT_W'(1);
        if (mem_ack) begin
          // Stores return no data, whatever the memory puts on the bus.
          cap_data_s = mem_we_r ? 32'h0000_0000 : mem_rdata;
          mem_req_s  = 1'b0;
          tout_s     = 1'b0;
          state_s    = DONE;
        end else if (cnt_r == CNT_W'(TIMEOUT - 1)) begin
          cap_data_s = 32'h0000_0000;
          mem_req_s  = 1'b0;
          tout_s     = 1'b1;
          state_s    = DONE;
        end else begin
          state_s = BUSY;
        end
      end
      DONE: begin
        wb_ctlout_s = tout_r ? 2'b00 : hold_wb_r;
        read_data_s = cap_data_r;
        alu_out_s   = hold_alu_r;
        rd_out_s    = hold_rd_r;
        mem_err_s   = tout_r;
        state_s     = IDLE;
      end
      default: begin
        state_s   = IDLE;
        mem_req_s = 1'b0;
      end
    endcase
  end

  // State, timeout counter, memory-port and MEM/WB registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r     <= IDLE;
      cnt_r       <= {CNT_W{1'b0}};
      mem_req_r   <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= 32'h0000_0000;
      mem_wdata_r <= 32'h0000_0000;
      cap_data_r  <= 32'h0000_0000;
      tout_r      <= 1'b0;
      hold_wb_r   <= 2'b00;
      hold_alu_r  <= 32'h0000_0000;
      hold_rd_r   <= 5'd0;
      wb_ctlout_r <= 2'b00;
      read_data_r <= 32'h0000_0000;
      alu_out_r   <= 32'h0000_0000;
      rd_out_r    <= 5'd0;
      mem_err_r   <= 1'b0;
    end else begin
      state_r     <= state_s;
      cnt_r       <= cnt_s;
      mem_req_r   <= mem_req_s;
      mem_we_r    <= mem_we_s;
      mem_addr_r  <= mem_addr_s;
      mem_wdata_r <= mem_wdata_s;
      cap_data_r  <= cap_data_s;
      tout_r      <= tout_s;
      hold_wb_r   <= hold_wb_s;
      hold_alu_r  <= hold_alu_s;
      hold_rd_r   <= hold_rd_s;
      wb_ctlout_r <= wb_ctlout_s;
      read_data_r <= read_data_s;
      alu_out_r   <= alu_out_s;
      rd_out_r    <= rd_out_s;
      mem_err_r   <= mem_err_s;
    end
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: directed operations, expected MEM/WB
// results queued when an op is driven and compared when it retires.
module tb_mem_wb_stage;

  logic        clock;
  logic        reset;
  logic [1:0]  wb_ctl;
  logic        branch;
  logic        memread;
  logic        memwrite;
  logic [31:0] add_result;
  logic        zero;
  logic [31:0] alu_result;
  logic [31:0] rdata2;
  logic [4:0]  rd;
  logic        pcsrc;
  logic [31:0] branch_target;
  logic        stall;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic [1:0]  wb_ctlout;
  logic [31:0] read_data;
  logic [31:0] alu_result_out;
  logic [4:0]  rd_out;
  logic        mem_err;

  typedef struct packed {
    logic [1:0]  wb;
    logic [31:0] rdata;
    logic [31:0] alu;
    logic [4:0]  rd;
    logic        err;
  } wb_t;

  wb_t sb[$];
  int  tests = 0;
  int  fails = 0;

  mem_wb_stage #(.TIMEOUT(16), .CNT_W(5)) dut (
    .clock(clock), .reset(reset), .wb_ctl(wb_ctl), .branch(branch),
    .memread(memread), .memwrite(memwrite), .add_result(add_result),
    .zero(zero), .alu_result(alu_result), .rdata2(rdata2), .rd(rd),
    .pcsrc(pcsrc), .branch_target(branch_target), .stall(stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .wb_ctlout(wb_ctlout), .read_data(read_data),
    .alu_result_out(alu_result_out), .rd_out(rd_out), .mem_err(mem_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [1:0] w, input logic mr, input logic mw,
                       input logic [31:0] a, input logic [31:0] d, input logic [4:0] r);
    wb_ctl = w; memread = mr; memwrite = mw; alu_result = a; rdata2 = d; rd = r;
    branch = 1'b0; zero = 1'b0; add_result = 32'h0;
  endtask

  task automatic push(input logic [1:0] w, input logic [31:0] rdat,
                      input logic [31:0] a, input logic [4:0] r, input logic e);
    wb_t x;
    x.wb = w; x.rdata = rdat; x.alu = a; x.rd = r; x.err = e;
    sb.push_back(x);
  endtask

  task automatic reset_checks(input string p);
    check({p, "_ctl"},   {60'h0, mem_req, mem_we, mem_err, stall}, 64'h0);
    check({p, "_addr"},  {32'h0, mem_addr}, 64'h0);
    check({p, "_wdata"}, {32'h0, mem_wdata}, 64'h0);
    check({p, "_wbrd"},  {57'h0, wb_ctlout, rd_out}, 64'h0);
    check({p, "_rdata"}, {32'h0, read_data}, 64'h0);
    check({p, "_alu"},   {32'h0, alu_result_out}, 64'h0);
  endtask

  // Called just after inputs were driven at a falling edge. Acks on the
  // ack_cycle-th cycle of mem_req (0 = never), checks bubbles while stalled,
  // then retires the op against the scoreboard and checks mem_err drops.
  task automatic do_op(input string tag, input int ack_cycle, input logic [31:0] rdat,
                       input int exp_stall, input int exp_req, input logic exp_we,
                       input logic [31:0] exp_addr, input logic [31:0] exp_wdata);
    int  stall_cnt = 0;
    int  req_cnt = 0;
    bit  done = 1'b0;
    wb_t e;
    for (int cyc = 0; cyc < 40; cyc++) begin
      #1;
      if (stall !== 1'b1) begin
        done = 1'b1;
        break;
      end
      stall_cnt++;
      if (mem_req === 1'b1) begin
        req_cnt++;
        check({tag, "_we"},    {63'h0, mem_we}, {63'h0, exp_we});
        check({tag, "_addr"},  {32'h0, mem_addr}, {32'h0, exp_addr});
        check({tag, "_wdata"}, {32'h0, mem_wdata}, {32'h0, exp_wdata});
        if (req_cnt == ack_cycle) begin
          mem_ack = 1'b1;
          mem_rdata = rdat;
        end
      end
      @(posedge clock);
      #1;
      mem_ack = 1'b0;
      mem_rdata = 32'h0;
      check({tag, "_bubble_ctl"}, {56'h0, wb_ctlout, rd_out, mem_err}, 64'h0);
      check({tag, "_bubble_data"}, {32'h0, read_data | alu_result_out}, 64'h0);
      @(negedge clock);
    end
    check({tag, "_stall_bounded"}, {63'h0, done}, 64'h1);
    check({tag, "_stall_cycles"}, 64'(stall_cnt), 64'(exp_stall));
    check({tag, "_req_cycles"}, 64'(req_cnt), 64'(exp_req));
    @(posedge clock);
    #1;
    check({tag, "_sb_depth"}, 64'(sb.size()), 64'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check({tag, "_wb_ctlout"}, {62'h0, wb_ctlout}, {62'h0, e.wb});
      check({tag, "_read_data"}, {32'h0, read_data}, {32'h0, e.rdata});
      check({tag, "_alu_out"},   {32'h0, alu_result_out}, {32'h0, e.alu});
      check({tag, "_rd_out"},    {59'h0, rd_out}, {59'h0, e.rd});
      check({tag, "_mem_err"},   {63'h0, mem_err}, {63'h0, e.err});
    end
    check({tag, "_req_idle"}, {63'h0, mem_req}, 64'h0);
    @(negedge clock);
    drive(2'b00, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    mem_ack = 1'b0;
    mem_rdata = 32'h0;
    @(posedge clock);
    #1;
    check({tag, "_err_pulse_end"}, {63'h0, mem_err}, 64'h0);
    @(negedge clock);
  endtask

  initial begin
    reset = 1'b1;
    mem_ack = 1'b0;
    mem_rdata = 32'h0;
    drive(2'b00, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    @(negedge clock);
    @(negedge clock);
    reset_checks("reset");
    reset = 1'b0;

    // Plain ALU op passes straight through
    drive(2'b10, 1'b0, 1'b0, 32'h0000_1234, 32'h0, 5'd5);
    push(2'b10, 32'h0, 32'h0000_1234, 5'd5, 1'b0);
    do_op("alu", 0, 32'h0, 0, 0, 1'b0, 32'h0, 32'h0);

    // Load, ack in third busy cycle
    drive(2'b11, 1'b1, 1'b0, 32'h0000_0040, 32'h0, 5'd7);
    push(2'b11, 32'hDEAD_BEEF, 32'h0000_0040, 5'd7, 1'b0);
    do_op("load", 3, 32'hDEAD_BEEF, 4, 3, 1'b0, 32'h0000_0040, 32'h0);

    // Store, immediate ack; bus data on ack must not reach read_data
    drive(2'b00, 1'b0, 1'b1, 32'h0000_0080, 32'hCAFE_0001, 5'd3);
    push(2'b00, 32'h0, 32'h0000_0080, 5'd3, 1'b0);
    do_op("store", 1, 32'h1234_5678, 2, 1, 1'b1, 32'h0000_0080, 32'hCAFE_0001);

    // Misaligned load
    drive(2'b11, 1'b1, 1'b0, 32'h0000_0041, 32'h0, 5'd9);
    push(2'b00, 32'h0, 32'h0000_0041, 5'd9, 1'b1);
    do_op("misaligned", 1, 32'h5555_5555, 0, 0, 1'b0, 32'h0, 32'h0);

    // Read and write together
    drive(2'b10, 1'b1, 1'b1, 32'h0000_0050, 32'h7777_7777, 5'd10);
    push(2'b00, 32'h0, 32'h0000_0050, 5'd10, 1'b1);
    do_op("illegal", 1, 32'h5555_5555, 0, 0, 1'b0, 32'h0, 32'h0);

    // No ack: aborted after 16 busy cycles
    drive(2'b11, 1'b1, 1'b0, 32'h0000_0060, 32'h0, 5'd12);
    push(2'b00, 32'h0, 32'h0000_0060, 5'd12, 1'b1);
    do_op("timeout", 0, 32'h0, 17, 16, 1'b0, 32'h0000_0060, 32'h0);

    // Reset in the middle of an access
    drive(2'b11, 1'b1, 1'b0, 32'h0000_0070, 32'h0, 5'd13);
    @(posedge clock);
    #1;
    check("midrst_req_up", {63'h0, mem_req}, 64'h1);
    @(negedge clock);
    @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    drive(2'b00, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    #1;
    reset_checks("midrst");
    @(negedge clock);
    reset = 1'b0;

    // Stray ack after reset is ignored; ALU op passes through
    drive(2'b10, 1'b0, 1'b0, 32'h0000_0099, 32'h0, 5'd4);
    mem_ack = 1'b1;
    mem_rdata = 32'hBAD0_BAD0;
    push(2'b10, 32'h0, 32'h0000_0099, 5'd4, 1'b0);
    do_op("stray_ack", 0, 32'h0, 0, 0, 1'b0, 32'h0, 32'h0);

    // Branch resolution
    drive(2'b00, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    branch = 1'b1; zero = 1'b1; add_result = 32'h0000_0100;
    #1;
    check("br_taken_pcsrc", {63'h0, pcsrc}, 64'h1);
    check("br_target", {32'h0, branch_target}, 64'h100);
    zero = 1'b0;
    #1;
    check("br_not_taken_pcsrc", {63'h0, pcsrc}, 64'h0);
    @(negedge clock);

    // Taken branch held off while a load stalls
    drive(2'b11, 1'b1, 1'b0, 32'h0000_0020, 32'h0, 5'd1);
    branch = 1'b1; zero = 1'b1; add_result = 32'h0000_0200;
    #1;
    check("br_stalled_pcsrc", {63'h0, pcsrc}, 64'h0);
    push(2'b11, 32'h0000_ABCD, 32'h0000_0020, 5'd1, 1'b0);
    do_op("load_br", 1, 32'h0000_ABCD, 2, 1, 1'b0, 32'h0000_0020, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
